// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receive FIFO here and by the transmit
// side in MMIO_Cntr: receiver state encoding, data width and baud divisor helper.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        RX_WAIT_IDLE = 3'd0,
        RX_IDLE      = 3'd1,
        RX_START     = 3'd2,
        RX_DATA      = 3'd3,
        RX_PARITY    = 3'd4,
        RX_STOP      = 3'd5
    } UartRxState;

    // Clocks per serial bit, integer-truncated (27 MHz / 115200 -> 234).
    function automatic int clks_per_bit(input int mhz, input int baud);
        return (mhz * 1_000_000) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// The head entry is presented on pop_data whenever the FIFO is non-empty and
// pop_data reads as zero when it is empty. A pop on an empty FIFO is ignored.
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH       = 8,
    parameter int DEPTH_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [DEPTH_WIDTH:0]   count
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] FULL_COUNT = (DEPTH_WIDTH + 1)'(DEPTH);

    logic [WIDTH-1:0]       mem [DEPTH];
    logic [DEPTH_WIDTH-1:0] wr_ptr;
    logic [DEPTH_WIDTH-1:0] rd_ptr;
    logic [DEPTH_WIDTH:0]   count_q;
    logic                   do_push;
    logic                   do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_COUNT);
    assign count    = count_q;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset because empty masks the output.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap modulo depth; occupancy is tracked in its own register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8-bit UART receiver feeding a byte FIFO read by MMIO_Cntr.
// Optional feature macro: UART_RX_PARITY_EN (8E1 framing with parity_error
// output); when undefined the frame is 8N1.
//
// Read handshake: rvalid high means rdata holds the oldest byte; asserting pop
// while rvalid is high consumes that byte on the next clock edge; pop while
// rvalid is low has no effect. There is no backpressure towards the line:
// a byte arriving while the FIFO is full is dropped and sets overflow.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int FMAX_MHz    = 27,
    parameter int BAUD_RATE   = 115200,
    parameter int DEPTH_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   uart_rx,
    output logic                   rvalid,
    output logic [7:0]             rdata,
    input  logic                   pop,
    output logic [DEPTH_WIDTH:0]   count,
    output logic                   overflow,
    output logic                   frame_error,
`ifdef UART_RX_PARITY_EN
    output logic                   parity_error,
`endif
    input  logic                   clear_err,
    output logic [2:0]             state_dbg
);

    localparam int CPB = clks_per_bit(FMAX_MHz, BAUD_RATE);
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CPB / 2 - 1);
    localparam logic [2:0] LAST_BIT    = 3'(UART_DATA_BITS - 1);

    localparam logic [2:0] S_WAIT_IDLE = RX_WAIT_IDLE;
    localparam logic [2:0] S_IDLE      = RX_IDLE;
    localparam logic [2:0] S_START     = RX_START;
    localparam logic [2:0] S_DATA      = RX_DATA;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY    = RX_PARITY;
`endif
    localparam logic [2:0] S_STOP      = RX_STOP;

    logic                      rx_meta;
    logic                      rx_s;
    logic [2:0]                state;
    logic [CW-1:0]             baud_cnt;
    logic [2:0]                bit_cnt;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      bit_end;
    logic                      half_end;
    logic                      par_ok;
    logic                      push;
    logic                      stop_bad;
    logic                      ovf_set;
    logic                      fifo_full;
    logic                      fifo_empty;

    assign bit_end   = (baud_cnt == BIT_END);
    assign half_end  = (baud_cnt == HALF_END);
    assign push      = (state == S_STOP) && bit_end && rx_s && par_ok;
    assign stop_bad  = (state == S_STOP) && bit_end && !rx_s;
    // A same-cycle pop frees a slot, so only a push into a full FIFO with no pop is lost.
    assign ovf_set   = push && fifo_full && !(pop && !fifo_empty);
    assign rvalid    = !fifo_empty;
    assign state_dbg = state;

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM with baud counter, bit counter and LSB-first shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_WAIT_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                S_WAIT_IDLE: begin
                    if (!rx_s) begin
                        baud_cnt <= '0;
                    end else if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (!rx_s) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (half_end) begin
                        baud_cnt <= '0;
                        state    <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        shreg    <= {rx_s, shreg[UART_DATA_BITS-1:1]};
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= rx_s ? S_IDLE : S_WAIT_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= S_WAIT_IDLE;
                    baud_cnt <= '0;
                end
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_set;
    assign par_set = (state == S_PARITY) && bit_end && (rx_s != ^shreg);

    // Parity verdict for the frame in flight; re-armed at every start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_ok <= 1'b1;
        end else if (state == S_START) begin
            par_ok <= 1'b1;
        end else if (par_set) begin
            par_ok <= 1'b0;
        end
    end

    // Sticky parity error; a new error wins over clear_err.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_error <= 1'b0;
        end else if (par_set) begin
            parity_error <= 1'b1;
        end else if (clear_err) begin
            parity_error <= 1'b0;
        end
    end
`else
    assign par_ok = 1'b1;
`endif

    // Sticky overflow and framing flags; a new error wins over clear_err.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clear_err) begin
                overflow <= 1'b0;
            end
            if (stop_bad) begin
                frame_error <= 1'b1;
            end else if (clear_err) begin
                frame_error <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH       (UART_DATA_BITS),
        .DEPTH_WIDTH (DEPTH_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (shreg),
        .pop       (pop),
        .pop_data  (rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

endmodule
